// File: rtl/pipelined_nbit_adder_pkg.sv
// Shared constants for the pipelined adder/subtractor.
// Mode values match the lab-wide ADD_MODE_ADD / ADD_MODE_SUB encodings.
package pipelined_nbit_adder_pkg;
    localparam logic ADD_MODE_ADD = 1'b0;
    localparam logic ADD_MODE_SUB = 1'b1;
endpackage

// File: rtl/add_mode_defs.sv
// Lab-wide add/subtract mode encodings shared with the multiplier labs.
// Guarded so it may be both compiled standalone and included.
`ifndef ADD_MODE_DEFS_SV
`define ADD_MODE_DEFS_SV
`define ADD_MODE_ADD 1'b0
`define ADD_MODE_SUB 1'b1
`endif

// File: rtl/pipelined_nbit_adder_slice.sv
// Ripple-carry slice built from full_adder cells; exposes the carry into its MSB.
// Latency: combinational.
// Backpressure: none (pure datapath).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout     = c[SLICE];
    assign c_msb_in = c[SLICE-1];
endmodule

// File: rtl/pipelined_nbit_adder.sv
// Pipelined ripple-carry adder/subtractor, one carry register per slice stage.
// Latency: STAGES cycles of advance; one result per cycle.
// Backpressure: whole pipe (bubbles included) freezes while out_valid & !out_ready.
module pipelined_nbit_adder
    import pipelined_nbit_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SLICE = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (sub == ADD_MODE_SUB) ? ~in2 : in2;
    assign c0       = (sub == ADD_MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when they reach stage k.
        localparam int REM = WIDTH - k * SLICE;

        logic [REM-1:0]         a_src;
        logic [REM-1:0]         b_src;
        logic                   c_src;
        logic                   v_src;
        logic [SLICE-1:0]       s;
        logic                   c_out;
        logic                   msb_carry;
        logic [(k+1)*SLICE-1:0] sum_d;
        logic [(k+1)*SLICE-1:0] sum_q;
        logic                   valid_q;
        logic                   carry_q;

        if (k == 0) begin : g_src
            assign a_src = in1;
            assign b_src = b_eff;
            assign c_src = c0;
            assign v_src = in_valid;
            assign sum_d = s;
        end else begin : g_src
            assign a_src = g_stage[k-1].g_hi.a_hi_q;
            assign b_src = g_stage[k-1].g_hi.b_hi_q;
            assign c_src = g_stage[k-1].carry_q;
            assign v_src = g_stage[k-1].valid_q;
            assign sum_d = {s, g_stage[k-1].sum_q};
        end

        adder_slice #(.SLICE(SLICE)) u_slice (
            .a        (a_src[SLICE-1:0]),
            .b        (b_src[SLICE-1:0]),
            .cin      (c_src),
            .s        (s),
            .cout     (c_out),
            .c_msb_in (msb_carry)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_src;
                carry_q <= c_out;
                sum_q   <= sum_d;
            end
        end

        // Upper operand slices travel alongside the carry until their stage.
        if (k < STAGES - 1) begin : g_hi
            logic [REM-SLICE-1:0] a_hi_q;
            logic [REM-SLICE-1:0] b_hi_q;
            logic                 msb_carry_unused;

            assign msb_carry_unused = msb_carry;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv) begin
                    a_hi_q <= a_src[REM-1:SLICE];
                    b_hi_q <= b_src[REM-1:SLICE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[STAGES-1].msb_carry ^ g_stage[STAGES-1].c_out;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Scoreboard bench for pipelined_nbit_adder at (8,1), (16,4) and (32,8).
module tb_pipelined_nbit_adder;
    localparam int N_RAND = 10000;
    localparam int BUDGET = 40000;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv32, ir32, ci32, sb32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, s32;

    int checks   = 0;
    int failures = 0;
    exp_t q8[$], q16[$], q32[$];

    pipelined_nbit_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
        .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
    pipelined_nbit_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
        .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16));
    pipelined_nbit_adder #(.WIDTH(32), .STAGES(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in1(a32), .in2(b32),
        .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32));

    // Reference: modulo sum, carry out of bit w-1, signed overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s, input int t);
        logic [31:0] mask, aa, bb;
        logic [32:0] full;
        exp_t e;
        mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa    = a & mask;
        bb    = (s ? ~b : b) & mask;
        full  = {1'b0, aa} + {1'b0, bb} + {32'b0, (s ? 1'b1 : c)};
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.t    = t;
        return e;
    endfunction

    // Drives one cycle on the 16-bit DUT and reports whether an accept / drain happens.
    task automatic step16(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic ordy,
                          output logic acc, output logic drn);
        @(negedge clk);
        rst = r; iv16 = v; a16 = a; b16 = b; ci16 = c; sb16 = s; or16 = ordy;
        #1;
        acc = v && ir16 && !r;
        drn = ov16 && ordy && !r;
    endtask

    task automatic test_reset();
        logic acc, drn;
        step16(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc, drn);
        step16(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc, drn);
        step16(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc, drn);
        checks++; if (ov16 !== 1'b0)     begin failures++; $display("FAIL reset_out_valid got=%b want=0", ov16); end
        checks++; if (s16 !== 16'h0000)  begin failures++; $display("FAIL reset_sum got=%h want=0000", s16); end
        checks++; if (co16 !== 1'b0)     begin failures++; $display("FAIL reset_cout got=%b want=0", co16); end
        checks++; if (of16 !== 1'b0)     begin failures++; $display("FAIL reset_ovf got=%b want=0", of16); end
        checks++; if (ir16 !== 1'b1)     begin failures++; $display("FAIL reset_in_ready got=%b want=1", ir16); end
        checks++; if (ov8 !== 1'b0 || ov32 !== 1'b0)
            begin failures++; $display("FAIL reset_other_valid got=%b%b want=00", ov8, ov32); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[5]  = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
        logic [15:0] vb[5]  = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
        logic        vc[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        vs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] es[5]  = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h1236};
        logic        ec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eo[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic acc, drn;
        exp_t e;
        int k;
        for (int i = 0; i < 12; i++) begin
            k = (i < 5) ? i : 4;
            step16(1'b0, i < 5, va[k], vb[k], vc[k], vs[k], 1'b1, acc, drn);
            if (drn) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected step=%0d sum=%h", i, s16);
                end else begin
                    e = q16.pop_front();
                    if (s16 !== e.sum[15:0] || co16 !== e.cout || of16 !== e.ovf) begin
                        failures++;
                        $display("FAIL b2b_result step=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 i, s16, co16, of16, e.sum[15:0], e.cout, e.ovf);
                    end
                    checks++;
                    if (i - e.t != 4) begin
                        failures++; $display("FAIL b2b_latency got=%0d want=4", i - e.t);
                    end
                end
            end
            if (acc) begin
                e.sum = {16'h0, es[k]}; e.cout = ec[k]; e.ovf = eo[k]; e.t = i;
                q16.push_back(e);
            end
        end
        checks++;
        if (q16.size() != 0) begin failures++; $display("FAIL b2b_drain left=%0d want=0", q16.size()); end
    endtask

    task automatic test_stall();
        logic [15:0] sa[6], sbv[6];
        logic        sc[6], ss[6];
        logic acc, drn, ordy;
        exp_t e;
        int nxt = 0, ndrn = 0, last = -1, nstall = 0, k;
        for (int i = 0; i < 6; i++) begin
            sa[i] = 16'($urandom()); sbv[i] = 16'($urandom());
            sc[i] = 1'($urandom()); ss[i] = 1'($urandom());
        end
        for (int i = 0; i < 24; i++) begin
            ordy = (i >= 8);
            k = (nxt < 6) ? nxt : 5;
            step16(1'b0, nxt < 6, sa[k], sbv[k], sc[k], ss[k], ordy, acc, drn);
            if (ov16 && !ordy) begin
                nstall++;
                checks++;
                if (ir16 !== 1'b0 || q16.size() == 0 || s16 !== q16[0].sum[15:0] ||
                    co16 !== q16[0].cout || of16 !== q16[0].ovf) begin
                    failures++;
                    $display("FAIL stall_hold step=%0d got in_ready=%b sum=%h want in_ready=0 sum=%h",
                             i, ir16, s16, q16[0].sum[15:0]);
                end
            end
            if (drn) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL stall_unexpected step=%0d sum=%h", i, s16);
                end else begin
                    e = q16.pop_front();
                    if (s16 !== e.sum[15:0] || co16 !== e.cout || of16 !== e.ovf) begin
                        failures++;
                        $display("FAIL stall_result step=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 i, s16, co16, of16, e.sum[15:0], e.cout, e.ovf);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (i - last != 1) begin failures++; $display("FAIL stall_gap got=%0d want=1", i - last); end
                end
                last = i;
                ndrn++;
            end
            if (acc) begin
                q16.push_back(model(16, {16'h0, sa[k]}, {16'h0, sbv[k]}, sc[k], ss[k], i));
                nxt++;
            end
        end
        checks++; if (nstall < 3) begin failures++; $display("FAIL stall_seen got=%0d want>=3", nstall); end
        checks++; if (ndrn != 6)  begin failures++; $display("FAIL stall_count got=%0d want=6", ndrn); end
    endtask

    task automatic test_reset_flush();
        logic acc, drn;
        exp_t e;
        int ndrn = 0;
        for (int i = 0; i < 3; i++)
            step16(1'b0, 1'b1, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 1'b1, acc, drn);
        step16(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, drn);
        q16.delete();
        for (int i = 0; i < 8; i++) begin
            step16(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, drn);
            checks++;
            if (ov16 !== 1'b0) begin failures++; $display("FAIL flush_valid step=%0d got=%b want=0", i, ov16); end
        end
        for (int i = 0; i < 10; i++) begin
            step16(1'b0, i == 0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1, acc, drn);
            if (drn) begin
                ndrn++;
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL flush_unexpected step=%0d sum=%h", i, s16);
                end else begin
                    e = q16.pop_front();
                    if (s16 !== e.sum[15:0] || co16 !== e.cout || of16 !== e.ovf || i - e.t != 4) begin
                        failures++;
                        $display("FAIL flush_result got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=4",
                                 s16, co16, of16, i - e.t, e.sum[15:0], e.cout, e.ovf);
                    end
                end
            end
            if (acc) begin
                e.sum = 32'h0000_1000; e.cout = 1'b0; e.ovf = 1'b0; e.t = i;
                q16.push_back(e);
            end
        end
        checks++; if (ndrn != 1) begin failures++; $display("FAIL flush_count got=%0d want=1", ndrn); end
    endtask

    task automatic test_random();
        int sent8 = 0, sent16 = 0, sent32 = 0, cyc = 0;
        exp_t e;
        while ((sent8 < N_RAND || sent16 < N_RAND || sent32 < N_RAND ||
                q8.size() != 0 || q16.size() != 0 || q32.size() != 0) && cyc < BUDGET) begin
            @(negedge clk);
            rst  = 1'b0;
            iv8  = (sent8  < N_RAND) && ($urandom_range(3) != 0);
            iv16 = (sent16 < N_RAND) && ($urandom_range(3) != 0);
            iv32 = (sent32 < N_RAND) && ($urandom_range(3) != 0);
            a8  = 8'($urandom());  b8  = 8'($urandom());  ci8  = 1'($urandom()); sb8  = 1'($urandom());
            a16 = 16'($urandom()); b16 = 16'($urandom()); ci16 = 1'($urandom()); sb16 = 1'($urandom());
            a32 = $urandom();      b32 = $urandom();      ci32 = 1'($urandom()); sb32 = 1'($urandom());
            or8  = ($urandom_range(3) != 0);
            or16 = ($urandom_range(3) != 0);
            or32 = ($urandom_range(3) != 0);
            #1;
            if (ov8 && or8) begin
                checks++;
                if (q8.size() == 0) begin failures++; $display("FAIL rand8_unexpected cyc=%0d sum=%h", cyc, s8); end
                else begin
                    e = q8.pop_front();
                    if (s8 !== e.sum[7:0] || co8 !== e.cout || of8 !== e.ovf) begin
                        failures++;
                        $display("FAIL rand8_result cyc=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 cyc, s8, co8, of8, e.sum[7:0], e.cout, e.ovf);
                    end
                end
            end
            if (ov16 && or16) begin
                checks++;
                if (q16.size() == 0) begin failures++; $display("FAIL rand16_unexpected cyc=%0d sum=%h", cyc, s16); end
                else begin
                    e = q16.pop_front();
                    if (s16 !== e.sum[15:0] || co16 !== e.cout || of16 !== e.ovf) begin
                        failures++;
                        $display("FAIL rand16_result cyc=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 cyc, s16, co16, of16, e.sum[15:0], e.cout, e.ovf);
                    end
                end
            end
            if (ov32 && or32) begin
                checks++;
                if (q32.size() == 0) begin failures++; $display("FAIL rand32_unexpected cyc=%0d sum=%h", cyc, s32); end
                else begin
                    e = q32.pop_front();
                    if (s32 !== e.sum || co32 !== e.cout || of32 !== e.ovf) begin
                        failures++;
                        $display("FAIL rand32_result cyc=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 cyc, s32, co32, of32, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (iv8 && ir8)   begin q8.push_back(model(8, {24'h0, a8}, {24'h0, b8}, ci8, sb8, cyc));       sent8++;  end
            if (iv16 && ir16) begin q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, ci16, sb16, cyc)); sent16++; end
            if (iv32 && ir32) begin q32.push_back(model(32, a32, b32, ci32, sb32, cyc));                   sent32++; end
            cyc++;
        end
        checks++;
        if (cyc >= BUDGET) begin
            failures++;
            $display("FAIL rand_timeout sent=%0d/%0d/%0d pending=%0d/%0d/%0d", sent8, sent16, sent32,
                     q8.size(), q16.size(), q32.size());
        end
        iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iv8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0; sb8  = 1'b0; or8  = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0; or16 = 1'b0;
        iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0; or32 = 1'b1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
